// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings and widths for the register-file command sequencer.
// Imported by the controller and by anything that decodes its opcodes.
package regfile_ctrl_pkg;

  localparam int RF_N = 16;
  localparam int RF_K = 3;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_READ = 2'b01,
    OP_MOVE = 2'b10,
    OP_SWAP = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    RESP = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_ctrl.sv
// Register-file command sequencer: turns LOAD/READ/MOVE/SWAP commands into
// multi-cycle read/write sequences on the raw port and returns one result word.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int n = RF_N,
  parameter int k = RF_K
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [k-1:0] cmd_rd,
  input  logic [k-1:0] cmd_rs,
  input  logic [n-1:0] cmd_imm,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_data,
  output logic         busy,
  output logic [n-1:0] rf_data_in,
  output logic [k-1:0] rf_writenum,
  output logic         rf_write,
  output logic [k-1:0] rf_readnum,
  input  logic [n-1:0] rf_data_out
);

  state_t       state_q, state_d;
  op_t          op_q;
  logic [k-1:0] rd_q, rs_q;
  logic [n-1:0] imm_q, tmp_a, tmp_b;

  // NOTE: state and captured operands use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      tmp_a   <= '0;
      tmp_b   <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_valid && cmd_ready) begin
        op_q  <= op_t'(cmd_op);
        rd_q  <= cmd_rd;
        rs_q  <= cmd_rs;
        imm_q <= cmd_imm;
      end
      if (state_q == RD_A) tmp_a <= rf_data_out;
      if (state_q == RD_B) tmp_b <= rf_data_out;
    end
  end

  // NOTE: every output and state_d gets a default before the case so no
  // path through the block leaves a value unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rf_write    = 1'b0;
    rf_writenum = '0;
    rf_readnum  = '0;
    rf_data_in  = '0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (op_t'(cmd_op) == OP_LOAD) ? WR_A : RD_A;
      end
      RD_A: begin
        rf_readnum = rs_q;
        case (op_q)
          OP_READ: state_d = RESP;
          OP_MOVE: state_d = WR_A;
          default: state_d = RD_B;
        endcase
      end
      RD_B: begin
        rf_readnum = rd_q;
        state_d    = WR_A;
      end
      WR_A: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = (op_q == OP_LOAD) ? imm_q : tmp_a;
        state_d     = (op_q == OP_SWAP) ? WR_B : RESP;
      end
      WR_B: begin
        rf_write    = 1'b1;
        rf_writenum = rs_q;
        rf_data_in  = tmp_b;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        // SWAP returns the old Rd, which was parked in tmp_b
        if (op_q == OP_LOAD)      rsp_data = imm_q;
        else if (op_q == OP_SWAP) rsp_data = tmp_b;
        else                      rsp_data = tmp_a;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural 8x16 register file as responder, a
// per-command timeline model checked every cycle, and directed plus random stimulus.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [2:0]  cmd_rd = 3'd0;
  logic [2:0]  cmd_rs = 3'd0;
  logic [15:0] cmd_imm = 16'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        busy;
  logic [15:0] rf_data_in;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [2:0]  rf_readnum;
  logic [15:0] rf_data_out;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  regfile_ctrl #(.n(16), .k(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .rf_data_in(rf_data_in), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_readnum(rf_readnum), .rf_data_out(rf_data_out)
  );

  // Register file responder: no reset, combinational read, write on clock.
  logic [15:0] rf_mem [0:7] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                                16'h4444, 16'h5555, 16'h6666, 16'h7777};
  int wr_pulses = 0;
  assign rf_data_out = rf_mem[rf_readnum];
  always @(posedge clk) begin
    if (rf_write) begin
      rf_mem[rf_writenum] <= rf_data_in;
      wr_pulses <= wr_pulses + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers as an array plus, for the command in flight,
  // the spec timeline indexed by cycles since accept (t = 1 is the first cycle).
  logic [15:0] model_mem [0:7] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333,
                                   16'h4444, 16'h5555, 16'h6666, 16'h7777};
  logic        in_flight = 1'b0;
  int          t = 0;
  int          m_lat = 0;
  logic [15:0] m_rsp = 16'h0;
  logic        m_wr   [0:7];
  logic [2:0]  m_wnum [0:7];
  logic [15:0] m_wdat [0:7];
  logic [2:0]  m_rnum [0:7];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= 1'b0;
      t         <= 0;
    end else if (in_flight) begin
      if (m_wr[t]) model_mem[m_wnum[t]] <= m_wdat[t];
      if (t >= m_lat) begin
        if (rsp_ready) in_flight <= 1'b0;
      end else begin
        t <= t + 1;
      end
    end else if (cmd_valid) begin
      for (int i = 0; i < 8; i++) begin
        m_wr[i] <= 1'b0; m_wnum[i] <= 3'd0; m_wdat[i] <= 16'h0; m_rnum[i] <= 3'd0;
      end
      in_flight <= 1'b1;
      t         <= 1;
      case (cmd_op)
        2'b00: begin
          m_wr[1] <= 1'b1; m_wnum[1] <= cmd_rd; m_wdat[1] <= cmd_imm;
          m_lat <= 2; m_rsp <= cmd_imm;
        end
        2'b01: begin
          m_rnum[1] <= cmd_rs;
          m_lat <= 2; m_rsp <= model_mem[cmd_rs];
        end
        2'b10: begin
          m_rnum[1] <= cmd_rs;
          m_wr[2] <= 1'b1; m_wnum[2] <= cmd_rd; m_wdat[2] <= model_mem[cmd_rs];
          m_lat <= 3; m_rsp <= model_mem[cmd_rs];
        end
        default: begin
          m_rnum[1] <= cmd_rs; m_rnum[2] <= cmd_rd;
          m_wr[3] <= 1'b1; m_wnum[3] <= cmd_rd; m_wdat[3] <= model_mem[cmd_rs];
          m_wr[4] <= 1'b1; m_wnum[4] <= cmd_rs; m_wdat[4] <= model_mem[cmd_rd];
          m_lat <= 5; m_rsp <= model_mem[cmd_rd];
        end
      endcase
    end
  end

  // Cycle-by-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rf_write", rf_write, 0);
      check("rst_writenum", rf_writenum, 0);
      check("rst_readnum", rf_readnum, 0);
      check("rst_data_in", rf_data_in, 0);
    end else if (!in_flight) begin
      check("idle_cmd_ready", cmd_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_rf_write", rf_write, 0);
      check("idle_readnum", rf_readnum, 0);
    end else begin
      check("op_cmd_ready", cmd_ready, 0);
      check("op_busy", busy, 1);
      check("op_rsp_valid", rsp_valid, (t >= m_lat) ? 1 : 0);
      check("op_rf_write", rf_write, m_wr[t]);
      check("op_readnum", rf_readnum, m_rnum[t]);
      if (m_wr[t]) begin
        check("op_writenum", rf_writenum, m_wnum[t]);
        check("op_data_in", rf_data_in, m_wdat[t]);
      end
      if (t >= m_lat) check("op_rsp_data", rsp_data, m_rsp);
    end
  end

  task automatic check_mem();
    for (int i = 0; i < 8; i++) check($sformatf("mem_r%0d", i), rf_mem[i], model_mem[i]);
  endtask

  // One command: issue, measure latency, optionally hold off the response
  // while throwing ignored commands at the DUT, then consume it.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [15:0] imm, input int hold,
                         output int lat, output logic [15:0] data);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
    rsp_ready = (hold == 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_rd = 3'($urandom); cmd_rs = 3'($urandom); cmd_imm = 16'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_arrives", rsp_valid, 1);
    data = rsp_data;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom); cmd_rd = 3'($urandom); cmd_rs = 3'($urandom); cmd_imm = 16'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_mem();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [15:0] data;
    int w0;

    #1 rst_n = 1'b0;
    #24;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rf_write", rf_write, 0);
    #7 rst_n = 1'b1;

    // LOAD R3
    w0 = wr_pulses;
    run_cmd(2'b00, 3'd3, 3'd0, 16'h00A5, 0, lat, data);
    check("load_lat", lat, 2);
    check("load_rsp", data, 16'h00A5);
    check("load_r3", rf_mem[3], 16'h00A5);
    check("load_pulses", wr_pulses - w0, 1);

    // MOVE R6 <- R1
    run_cmd(2'b00, 3'd1, 3'd0, 16'h1234, 0, lat, data);
    run_cmd(2'b10, 3'd6, 3'd1, 16'h0, 1, lat, data);
    check("move_lat", lat, 3);
    check("move_rsp", data, 16'h1234);
    check("move_r6", rf_mem[6], 16'h1234);
    check("move_r1", rf_mem[1], 16'h1234);

    // SWAP R2 <-> R5
    run_cmd(2'b00, 3'd2, 3'd0, 16'hBEEF, 0, lat, data);
    run_cmd(2'b00, 3'd5, 3'd0, 16'h0F0F, 0, lat, data);
    run_cmd(2'b11, 3'd2, 3'd5, 16'h0, 0, lat, data);
    check("swap_lat", lat, 5);
    check("swap_rsp", data, 16'hBEEF);
    check("swap_r2", rf_mem[2], 16'h0F0F);
    check("swap_r5", rf_mem[5], 16'hBEEF);

    // SWAP with rd == rs
    run_cmd(2'b00, 3'd4, 3'd0, 16'h7777, 0, lat, data);
    w0 = wr_pulses;
    run_cmd(2'b11, 3'd4, 3'd4, 16'h0, 2, lat, data);
    check("swap44_rsp", data, 16'h7777);
    check("swap44_r4", rf_mem[4], 16'h7777);
    check("swap44_pulses", wr_pulses - w0, 2);

    // READ R0 under 4 cycles of backpressure with stray commands
    run_cmd(2'b00, 3'd0, 3'd0, 16'hC0DE, 0, lat, data);
    w0 = wr_pulses;
    run_cmd(2'b01, 3'd7, 3'd0, 16'h0, 4, lat, data);
    check("read_lat", lat, 2);
    check("read_rsp", data, 16'hC0DE);
    check("read_pulses", wr_pulses - w0, 0);

    // Reset in the middle of WR_B of a SWAP R6 <-> R7
    run_cmd(2'b00, 3'd6, 3'd0, 16'hAAAA, 0, lat, data);
    run_cmd(2'b00, 3'd7, 3'd0, 16'h5555, 0, lat, data);
    w0 = wr_pulses;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rd = 3'd6; cmd_rs = 3'd7; rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_wrb_write", rf_write, 1);
    check("abort_wrb_num", rf_writenum, 3'd7);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rf_write", rf_write, 0);
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_writenum", rf_writenum, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    rsp_ready = 1'b0;
    check("abort_r6", rf_mem[6], 16'h5555);
    check("abort_r7", rf_mem[7], 16'h5555);
    check("abort_pulses", wr_pulses - w0, 1);
    check_mem();
    run_cmd(2'b00, 3'd7, 3'd0, 16'h0BAD, 0, lat, data);
    check("post_lat", lat, 2);
    check("post_rsp", data, 16'h0BAD);
    check("post_r7", rf_mem[7], 16'h0BAD);

    // Random traffic, checked by the cycle compare and memory compare
    for (int i = 0; i < 150; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              16'($urandom), $urandom_range(0, 3), lat, data);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
